// File: rtl/alu_pkg.sv
// Shared operation codes and FSM encoding for the sequential ALU.
package alu_pkg;

    localparam logic [3:0] ALU_ONE  = 4'b0000;
    localparam logic [3:0] ALU_ADD  = 4'b0001;
    localparam logic [3:0] ALU_SUB  = 4'b0010;
    localparam logic [3:0] ALU_AND  = 4'b0011;
    localparam logic [3:0] ALU_OR   = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_EQ   = 4'b0110;
    localparam logic [3:0] ALU_ONE7 = 4'b0111;
    localparam logic [3:0] ALU_MULU = 4'b1000;
    localparam logic [3:0] ALU_DIVU = 4'b1001;
    localparam logic [3:0] ALU_SLTU = 4'b1010;
    localparam logic [3:0] ALU_XOR  = 4'b1011;
    localparam logic [3:0] ALU_NOR  = 4'b1100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIN  = 2'd3
    } state_t;

endpackage

// File: rtl/alu_comb.sv
// Single-cycle ALU operations and signed overflow detection.
module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       ctr,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] t,
    output logic [WIDTH-1:0] result,
    output logic             overflow
);

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             slt;
    logic             sltu;

    assign sum  = s + t;
    assign diff = s - t;
    assign slt  = $signed(s) < $signed(t);
    assign sltu = s < t;

    always_comb begin
        result   = WIDTH'(1);
        overflow = 1'b0;
        case (ctr)
            ALU_ADD: begin
                result   = sum;
                overflow = (s[WIDTH-1] == t[WIDTH-1]) &&
                           (sum[WIDTH-1] != s[WIDTH-1]);
            end
            ALU_SUB: begin
                result   = diff;
                overflow = (s[WIDTH-1] != t[WIDTH-1]) &&
                           (diff[WIDTH-1] != s[WIDTH-1]);
            end
            ALU_AND:  result = s & t;
            ALU_OR:   result = s | t;
            ALU_SLT:  result = {{(WIDTH-1){1'b0}}, slt};
            ALU_EQ:   result = {{(WIDTH-1){1'b0}}, s == t};
            ALU_SLTU: result = {{(WIDTH-1){1'b0}}, sltu};
            ALU_XOR:  result = s ^ t;
            ALU_NOR:  result = ~(s | t);
            default:  result = WIDTH'(1);
        endcase
    end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle EX-stage ALU: single-cycle ops plus iterative
// unsigned shift-add multiply and restoring divide.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       Ctr,
    input  logic [WIDTH-1:0] S,
    input  logic [WIDTH-1:0] T,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Result,
    output logic [WIDTH-1:0] Hi,
    output logic             Overflow,
    output logic             Zero
);

    state_t state;
    state_t state_nx;

    logic [WIDTH-1:0] comb_res;
    logic             comb_ovf;

    // acc holds the product high half or the remainder; mq holds the
    // multiplier or the dividend/quotient; opd is the other operand.
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mq;
    logic [WIDTH-1:0] opd;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] hi_q;
    logic             ovf_q;
    logic             zero_q;

    logic             is_mul;
    logic             is_div;
    logic             div0;
    logic             last;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_ok;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;
    logic [WIDTH-1:0] one_res;
    logic [WIDTH-1:0] one_hi;

    alu_comb #(.WIDTH(WIDTH)) u_comb (
        .ctr      (Ctr),
        .s        (S),
        .t        (T),
        .result   (comb_res),
        .overflow (comb_ovf)
    );

    assign is_mul = Ctr == ALU_MULU;
    assign is_div = Ctr == ALU_DIVU;
    assign div0   = is_div && (T == '0);
    assign last   = cnt == CNT_W'(1);

    assign one_res = div0 ? '1 : comb_res;
    assign one_hi  = div0 ? S : '0;

    assign mul_sum   = {1'b0, acc} + {1'b0, (mq[0] ? opd : '0)};
    assign div_shift = {acc, mq[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opd};
    assign div_ok    = !div_diff[WIDTH];

    always_comb begin
        step_hi = '0;
        step_lo = '0;
        if (state == MUL) begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], mq[WIDTH-1:1]};
        end else begin
            step_hi = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            step_lo = {mq[WIDTH-2:0], div_ok};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (is_mul)              state_nx = MUL;
                    else if (is_div && !div0) state_nx = DIV;
                    else                     state_nx = FIN;
                end
            end
            MUL, DIV: if (last) state_nx = FIN;
            FIN:      state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy = state != IDLE;
        done = state == FIN;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc    <= '0;
            mq     <= '0;
            opd    <= '0;
            cnt    <= '0;
            res_q  <= '0;
            hi_q   <= '0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (is_mul) begin
                            opd <= S;
                            mq  <= T;
                            acc <= '0;
                            cnt <= CNT_W'(WIDTH);
                        end else if (is_div && !div0) begin
                            opd <= T;
                            mq  <= S;
                            acc <= '0;
                            cnt <= CNT_W'(WIDTH);
                        end else begin
                            res_q  <= one_res;
                            hi_q   <= one_hi;
                            ovf_q  <= comb_ovf;
                            zero_q <= one_res == '0;
                        end
                    end
                end
                MUL, DIV: begin
                    acc <= step_hi;
                    mq  <= step_lo;
                    cnt <= cnt - CNT_W'(1);
                    if (last) begin
                        res_q  <= step_lo;
                        hi_q   <= step_hi;
                        ovf_q  <= 1'b0;
                        zero_q <= step_lo == '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign Result   = res_q;
    assign Hi       = hi_q;
    assign Overflow = ovf_q;
    assign Zero     = zero_q;

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, multi-cycle successor to the datapath ALU. Adds iterative unsigned multiply and divide, unsigned compare, XOR and NOR, plus overflow and zero flags.
- Sits in the EX stage. Takes one operation per start pulse; the controller stalls the pipeline while busy=1.
- All results are registered; the block has no combinational path from inputs to outputs.

Parameters:
- WIDTH, 32, operand and result width in bits; must be >= 4.
- CNT_W, $clog2(WIDTH)+1, width of the iteration counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  launches the operation on Ctr/S/T; sampled only while busy=0.
- Ctr  input  4  operation select (codes below).
- S  input  WIDTH  operand A.
- T  input  WIDTH  operand B.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse; Result, Hi and flags are valid from this cycle.
- Result  output  WIDTH  primary result (low product or quotient for MULU/DIVU).
- Hi  output  WIDTH  high product (MULU) or remainder (DIVU); 0 for all other ops.
- Overflow  output  1  signed overflow for ADD/SUB; 0 otherwise.
- Zero  output  1  Result == 0.

Behaviour:
- Ctr codes:
  - 0000 ONE; 0001 ADD; 0010 SUB; 0011 AND; 0100 OR.
  - 0101 SLT (signed); 0110 EQ; 0111 ONE.
  - 1000 MULU; 1001 DIVU; 1010 SLTU; 1011 XOR; 1100 NOR.
  - 1101-1111 ONE.
- ONE: Result = 1.
- SLT/SLTU/EQ: Result = 1 or 0. SLT is a true signed compare and is correct even when S-T overflows.
- ADD/SUB: modulo 2^WIDTH. Overflow = operand signs agree (ADD) or differ (SUB) and the result sign differs from S.
- Reset: state IDLE; busy=0, done=0, Result=0, Hi=0, Overflow=0, Zero=1; counter=0. Reset mid-operation aborts it, with no done pulse.
- FSM states: IDLE, MUL, DIV, FIN.
  - IDLE & start & single-cycle op (or DIVU with T==0): compute, register outputs -> FIN. busy=1 in FIN, done=1 in FIN. Latency is 1 cycle, so done is asserted on the edge after start.
  - IDLE & start & MULU: latch S and T; acc=0; counter=WIDTH -> MUL.
  - IDLE & start & DIVU & T!=0: latch S and T; rem=0; counter=WIDTH -> DIV.
  - MUL: one shift-add step per cycle, LSB first, into a 2*WIDTH product. counter-- ; when the counter reaches 1, the last step is done -> FIN.
  - DIV: one restoring step per cycle, MSB first. counter-- ; same exit rule -> FIN.
  - FIN: done=1 for exactly one cycle -> IDLE. busy=0 in the next cycle.
- MULU/DIVU latency: done asserted WIDTH+1 cycles after the start edge. busy=1 for WIDTH+1 cycles.
- MULU: {Hi,Result} = S*T, unsigned, full 2*WIDTH bits.
- DIVU by zero: Result = all ones, Hi = S, latency 1, Overflow = 0.
- start while busy=1 is ignored; operands are not re-sampled. S, T and Ctr may change freely after the start cycle.
- start in the same cycle as reset: reset wins.
- Back-to-back: start may be asserted in the first cycle after done (busy=0). Maximum throughput is one single-cycle op every 2 cycles.
- Outputs hold their last values between operations until the next done.

Decomposition:
- Package alu_pkg holds:
  - the Ctr code localparams (ALU_ONE, ALU_ADD, ... ALU_NOR);
  - the FSM state encoding (IDLE, MUL, DIV, FIN).
- One sub-module, alu_comb: purely combinational single-cycle ops plus the Overflow flag, parametrised by WIDTH. seq_alu instantiates it and keeps the FSM, the iterative mul/div datapath and the output registers.

Test Plan:
- Reset held for 2 cycles, then released -> busy=0, done=0, Result=0, Hi=0, Zero=1, Overflow=0.
- ADD, S=32'h7FFFFFFF, T=1 -> done 1 cycle later; Result=32'h80000000, Overflow=1, Zero=0. SUB, S=5, T=5 -> Result=0, Zero=1, Overflow=0.
- SLT, S=32'h80000000, T=1 -> Result=1. SLTU on the same operands -> Result=0. EQ, S=T=32'hDEADBEEF -> Result=1.
- MULU, S=32'hFFFFFFFF, T=32'hFFFFFFFF -> done exactly 33 cycles after start; Hi=32'hFFFFFFFE, Result=1. start pulses while busy are ignored.
- DIVU, S=100, T=7 -> done after 33 cycles; Result=14, Hi=2. DIVU, S=9, T=0 -> done after 1 cycle; Result=32'hFFFFFFFF, Hi=9.
- MULU start, then reset at cycle 10 -> no done pulse; all outputs at reset values. A following ADD 2+3 completes with Result=5.
